// File: rtl/vend_pkg.sv
// Shared types for the multi-item vending controller: FSM state encoding,
// coin codes and the coin code to value mapping.
package vend_pkg;

    localparam int COIN_VAL_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_RECEIVE = 3'd2,
        S_COMPARE = 3'd3,
        S_VEND    = 3'd4,
        S_RETURN  = 3'd5
    } vend_state_e;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VAL_W-1:0] v;
        case (code)
            COIN_5:  v = COIN_VAL_W'(5);
            COIN_10: v = COIN_VAL_W'(10);
            COIN_20: v = COIN_VAL_W'(20);
            default: v = COIN_VAL_W'(50);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Request/response bundle of the vending controller.
// Restock ports exist only when VEND_STOCK_EN is defined.
interface vend_ctrl_multi_if #(
    parameter int IW      = 2,
    parameter int MONEY_W = 8
);
    logic               start;
    logic               cancel;
    logic               continue_buy;
    logic               done_money;
    logic               item_valid;
    logic [IW-1:0]      item_in;
    logic               coin_valid;
    logic [1:0]         coin_code;
`ifdef VEND_STOCK_EN
    logic               restock_valid;
    logic [IW-1:0]      restock_item;
`endif
    logic [2:0]         state;
    logic [MONEY_W-1:0] credit;
    logic [MONEY_W-1:0] price;
    logic               vend_valid;
    logic [IW-1:0]      vend_item;
    logic               change_valid;
    logic [MONEY_W-1:0] change_amt;
    logic               end_trans;
    logic               coin_reject;
    logic               insufficient;
    logic               sold_out;

`ifdef VEND_STOCK_EN
    modport master (
        output start, cancel, continue_buy, done_money,
        output item_valid, item_in, coin_valid, coin_code,
        output restock_valid, restock_item,
        input  state, credit, price, vend_valid, vend_item,
        input  change_valid, change_amt, end_trans,
        input  coin_reject, insufficient, sold_out
    );
    modport slave (
        input  start, cancel, continue_buy, done_money,
        input  item_valid, item_in, coin_valid, coin_code,
        input  restock_valid, restock_item,
        output state, credit, price, vend_valid, vend_item,
        output change_valid, change_amt, end_trans,
        output coin_reject, insufficient, sold_out
    );
`else
    modport master (
        output start, cancel, continue_buy, done_money,
        output item_valid, item_in, coin_valid, coin_code,
        input  state, credit, price, vend_valid, vend_item,
        input  change_valid, change_amt, end_trans,
        input  coin_reject, insufficient, sold_out
    );
    modport slave (
        input  start, cancel, continue_buy, done_money,
        input  item_valid, item_in, coin_valid, coin_code,
        output state, credit, price, vend_valid, vend_item,
        output change_valid, change_amt, end_trans,
        output coin_reject, insufficient, sold_out
    );
`endif

endinterface

// File: rtl/vend_stock.sv
// Per-item stock counters: decrement on dispense, restock to full scale.
module vend_stock #(
    parameter int N_ITEMS    = 4,
    parameter int IW         = 2,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dec_valid,
    input  logic [IW-1:0] dec_item,
    input  logic          restock_valid,
    input  logic [IW-1:0] restock_item,
    input  logic [IW-1:0] query_item,
    output logic          in_stock
);

    logic [STOCK_W-1:0] cnt_q [N_ITEMS];

    // Restock wins over a same-cycle dispense of the same item
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ITEMS; i++)
                cnt_q[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (restock_valid && restock_item == IW'(i))
                    cnt_q[i] <= '1;
                else if (dec_valid && dec_item == IW'(i) && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - STOCK_W'(1);
            end
        end
    end

    assign in_stock = (cnt_q[query_item] != '0);

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: select, pay, compare, vend, return change.
// Define VEND_STOCK_EN to add per-item stock tracking and restock ports.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = 4,
    parameter int IW         = $clog2(N_ITEMS),
    parameter int MONEY_W    = 8,
    parameter int MAX_CREDIT = 200,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICE_TABLE =
        {8'd60, 8'd15, 8'd40, 8'd25},
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 7
) (
    input logic clk,
    input logic reset_n,
    vend_ctrl_multi_if.slave bus
);

    vend_state_e        st_q, st_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [IW-1:0]      item_q, item_d;
    logic [IW-1:0]      vitem_q, vitem_d;
    logic [MONEY_W:0]   sum;
    logic               in_stock;
    logic               item_ok;
    logic               coin_rej;
    logic               insuff;
    logic               sold;

    assign item_ok = (32'(bus.item_in) < N_ITEMS);

`ifdef VEND_STOCK_EN
    vend_stock #(
        .N_ITEMS   (N_ITEMS),
        .IW        (IW),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
    ) u_stock (
        .clk          (clk),
        .reset_n      (reset_n),
        .dec_valid    (st_q == S_VEND),
        .dec_item     (item_q),
        .restock_valid(bus.restock_valid),
        .restock_item (bus.restock_item),
        .query_item   (bus.item_in),
        .in_stock     (in_stock)
    );
`else
    logic unused_stock_cfg;
    assign unused_stock_cfg = ^{STOCK_W[0], INIT_STOCK[0]};
    assign in_stock = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q     <= S_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            change_q <= '0;
            item_q   <= '0;
            vitem_q  <= '0;
        end else begin
            st_q     <= st_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            change_q <= change_d;
            item_q   <= item_d;
            vitem_q  <= vitem_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        credit_d = credit_q;
        price_d  = price_q;
        change_d = change_q;
        item_d   = item_q;
        vitem_d  = vitem_q;
        coin_rej = 1'b0;
        insuff   = 1'b0;
        sold     = 1'b0;
        sum      = {1'b0, credit_q}
                 + (MONEY_W+1)'(coin_value(bus.coin_code));
        case (st_q)
            S_IDLE: begin
                if (bus.start) st_d = S_SELECT;
            end
            S_SELECT: begin
                if (bus.cancel) begin
                    st_d = S_IDLE;
                end else if (bus.item_valid && item_ok) begin
                    if (in_stock) begin
                        item_d  = bus.item_in;
                        price_d = PRICE_TABLE[int'(bus.item_in)*MONEY_W +: MONEY_W];
                        st_d    = S_RECEIVE;
                    end else begin
                        sold = 1'b1;
                    end
                end
            end
            S_RECEIVE: begin
                if (bus.coin_valid) begin
                    if (sum > (MONEY_W+1)'(MAX_CREDIT))
                        coin_rej = 1'b1;
                    else
                        credit_d = sum[MONEY_W-1:0];
                end
                // Refund includes a coin accepted in the cancel cycle
                if (bus.cancel) begin
                    change_d = credit_d;
                    st_d     = S_RETURN;
                end else if (bus.done_money) begin
                    st_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (bus.cancel) begin
                    change_d = credit_q;
                    st_d     = S_RETURN;
                end else if (credit_q >= price_q) begin
                    vitem_d = item_q;
                    st_d    = S_VEND;
                end else begin
                    insuff = 1'b1;
                    st_d   = S_RECEIVE;
                end
            end
            S_VEND: begin
                change_d = credit_q - price_q;
                st_d     = S_RETURN;
            end
            S_RETURN: begin
                credit_d = '0;
                st_d     = bus.continue_buy ? S_SELECT : S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    assign bus.state        = st_q;
    assign bus.credit       = credit_q;
    assign bus.price        = price_q;
    assign bus.vend_valid   = (st_q == S_VEND);
    assign bus.vend_item    = vitem_q;
    assign bus.change_valid = (st_q == S_RETURN);
    assign bus.change_amt   = change_q;
    assign bus.end_trans    = (st_q == S_RETURN);
    assign bus.coin_reject  = coin_rej;
    assign bus.insufficient = insuff;
    assign bus.sold_out     = sold;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed and randomized checks of vend_ctrl_multi against a behavioural model.
module tb_vend_ctrl_multi;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    vend_ctrl_multi_if bus ();

    vend_ctrl_multi dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int coin_vals [4] = '{5, 10, 20, 50};
    int prices    [4] = '{25, 40, 15, 60};

    task automatic clear_in();
        bus.start = 0; bus.cancel = 0; bus.continue_buy = 0;
        bus.done_money = 0; bus.item_valid = 0; bus.item_in = 0;
        bus.coin_valid = 0; bus.coin_code = 0;
`ifdef VEND_STOCK_EN
        bus.restock_valid = 0; bus.restock_item = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start_select(input int item);
        clear_in(); bus.start = 1; tick();
        clear_in(); bus.item_valid = 1; bus.item_in = 2'(item); tick();
        clear_in();
    endtask

    task automatic do_coin(input int code);
        bus.coin_valid = 1; bus.coin_code = 2'(code); tick();
        clear_in();
    endtask

    task automatic test_reset();
        clear_in(); reset_n = 0; tick(); tick();
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        total++; if (bus.credit !== 8'd0) begin bad++; $display("FAIL rst_credit got=%0d exp=0", bus.credit); end
        total++; if (bus.price !== 8'd0) begin bad++; $display("FAIL rst_price got=%0d exp=0", bus.price); end
        total++; if (bus.change_amt !== 8'd0) begin bad++; $display("FAIL rst_change got=%0d exp=0", bus.change_amt); end
        total++;
        if ({bus.vend_valid, bus.change_valid, bus.end_trans, bus.coin_reject,
             bus.insufficient, bus.sold_out} !== 6'b0 || bus.vend_item !== 2'd0) begin
            bad++; $display("FAIL rst_pulses got=%b item=%0d exp=0",
                {bus.vend_valid, bus.change_valid, bus.end_trans, bus.coin_reject,
                 bus.insufficient, bus.sold_out}, bus.vend_item);
        end
        reset_n = 1; tick();
    endtask

    task automatic test_purchase();
        clear_in(); bus.start = 1; tick(); clear_in();
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL buy_select got=%0d exp=1", bus.state); end
        bus.item_valid = 1; bus.item_in = 2'd1; tick(); clear_in();
        total++; if (bus.state !== 3'd2 || bus.price !== 8'd40) begin bad++; $display("FAIL buy_latch state=%0d price=%0d exp 2/40", bus.state, bus.price); end
        do_coin(2); do_coin(2); do_coin(1);
        total++; if (bus.credit !== 8'd50) begin bad++; $display("FAIL buy_credit got=%0d exp=50", bus.credit); end
        bus.done_money = 1; tick(); clear_in();
        total++; if (bus.state !== 3'd3 || bus.insufficient !== 1'b0) begin bad++; $display("FAIL buy_compare state=%0d ins=%0d exp 3/0", bus.state, bus.insufficient); end
        tick();
        total++; if (bus.vend_valid !== 1'b1 || bus.vend_item !== 2'd1) begin bad++; $display("FAIL buy_vend valid=%0d item=%0d exp 1/1", bus.vend_valid, bus.vend_item); end
        tick();
        total++; if (bus.change_valid !== 1'b1 || bus.end_trans !== 1'b1 || bus.change_amt !== 8'd10) begin
            bad++; $display("FAIL buy_change valid=%0d end=%0d amt=%0d exp 1/1/10", bus.change_valid, bus.end_trans, bus.change_amt); end
        tick();
        total++; if (bus.state !== 3'd0 || bus.credit !== 8'd0) begin bad++; $display("FAIL buy_idle state=%0d credit=%0d exp 0/0", bus.state, bus.credit); end
    endtask

    task automatic test_insufficient();
        do_start_select(3);
        do_coin(3);
        bus.done_money = 1; tick(); clear_in();
        total++; if (bus.insufficient !== 1'b1) begin bad++; $display("FAIL ins_pulse got=%0d exp=1", bus.insufficient); end
        tick();
        total++; if (bus.state !== 3'd2 || bus.credit !== 8'd50) begin bad++; $display("FAIL ins_back state=%0d credit=%0d exp 2/50", bus.state, bus.credit); end
        do_coin(1);
        bus.done_money = 1; tick(); clear_in(); tick();
        total++; if (bus.vend_valid !== 1'b1 || bus.vend_item !== 2'd3) begin bad++; $display("FAIL ins_vend valid=%0d item=%0d exp 1/3", bus.vend_valid, bus.vend_item); end
        tick();
        total++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd0) begin bad++; $display("FAIL ins_change valid=%0d amt=%0d exp 1/0", bus.change_valid, bus.change_amt); end
        tick();
    endtask

    task automatic test_coin_reject();
        do_start_select(0);
        do_coin(3); do_coin(3); do_coin(3); do_coin(2); do_coin(2);
        total++; if (bus.credit !== 8'd190) begin bad++; $display("FAIL rej_pre got=%0d exp=190", bus.credit); end
        bus.coin_valid = 1; bus.coin_code = 2'd2; #1;
        total++; if (bus.coin_reject !== 1'b1) begin bad++; $display("FAIL rej_pulse got=%0d exp=1", bus.coin_reject); end
        tick(); clear_in();
        total++; if (bus.credit !== 8'd190) begin bad++; $display("FAIL rej_hold got=%0d exp=190", bus.credit); end
        bus.coin_valid = 1; bus.coin_code = 2'd1; #1;
        total++; if (bus.coin_reject !== 1'b0) begin bad++; $display("FAIL rej_edge got=%0d exp=0", bus.coin_reject); end
        tick(); clear_in();
        total++; if (bus.credit !== 8'd200) begin bad++; $display("FAIL rej_max got=%0d exp=200", bus.credit); end
        bus.cancel = 1; tick(); clear_in();
        total++; if (bus.change_amt !== 8'd200) begin bad++; $display("FAIL rej_refund got=%0d exp=200", bus.change_amt); end
        tick();
    endtask

    task automatic test_cancel();
        do_start_select(0);
        do_coin(2); do_coin(1); do_coin(0);
        bus.cancel = 1; bus.coin_valid = 1; bus.coin_code = 2'd0; tick(); clear_in();
        total++; if (bus.state !== 3'd5 || bus.vend_valid !== 1'b0 || bus.change_amt !== 8'd40) begin
            bad++; $display("FAIL cancel_refund state=%0d vend=%0d amt=%0d exp 5/0/40", bus.state, bus.vend_valid, bus.change_amt); end
        bus.continue_buy = 1; tick(); clear_in();
        total++; if (bus.state !== 3'd1 || bus.credit !== 8'd0) begin bad++; $display("FAIL cancel_cont state=%0d credit=%0d exp 1/0", bus.state, bus.credit); end
        bus.cancel = 1; tick(); clear_in();
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL cancel_sel got=%0d exp=0", bus.state); end
    endtask

    task automatic test_reset_mid();
        do_start_select(2);
        do_coin(2); do_coin(1);
        total++; if (bus.credit !== 8'd30) begin bad++; $display("FAIL rmid_pre got=%0d exp=30", bus.credit); end
        reset_n = 0; tick();
        total++; if (bus.state !== 3'd0 || bus.credit !== 8'd0 || bus.change_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_reset state=%0d credit=%0d chg=%0d exp 0/0/0", bus.state, bus.credit, bus.change_valid); end
        reset_n = 1; tick();
        total++; if (bus.change_valid !== 1'b0 || bus.state !== 3'd0) begin bad++; $display("FAIL rmid_after chg=%0d state=%0d exp 0/0", bus.change_valid, bus.state); end
    endtask

`ifdef VEND_STOCK_EN
    task automatic test_stock();
        for (int n = 0; n < 7; n++) begin
            do_start_select(0);
            do_coin(3);
            bus.done_money = 1; tick(); clear_in(); tick();
            total++; if (bus.vend_valid !== 1'b1) begin bad++; $display("FAIL stock_buy%0d vend=%0d exp=1", n, bus.vend_valid); end
            tick(); tick();
        end
        bus.start = 1; tick(); clear_in();
        bus.item_valid = 1; bus.item_in = 2'd0; #1;
        total++; if (bus.sold_out !== 1'b1) begin bad++; $display("FAIL stock_sold got=%0d exp=1", bus.sold_out); end
        tick(); clear_in();
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL stock_hold got=%0d exp=1", bus.state); end
        bus.restock_valid = 1; bus.restock_item = 2'd0; tick(); clear_in();
        bus.item_valid = 1; bus.item_in = 2'd0; tick(); clear_in();
        total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL stock_restock got=%0d exp=2", bus.state); end
        bus.cancel = 1; tick(); clear_in(); tick();
    endtask
`endif

    task automatic test_random();
        int m_st, m_cr, m_pr, m_item, m_vitem, m_chg;
        int m_stock [4];
        int n_st, e_rej, e_ins, e_sold, add;
        clear_in(); reset_n = 0; tick(); reset_n = 1;
        m_st = 0; m_cr = 0; m_pr = 0; m_item = 0; m_vitem = 0; m_chg = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 7;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.start        = 1'($urandom % 2);
            bus.cancel       = ($urandom % 12) == 0;
            bus.continue_buy = 1'($urandom % 2);
            bus.done_money   = ($urandom % 4) == 0;
            bus.item_valid   = 1'($urandom % 2);
            bus.item_in      = 2'($urandom % 4);
            bus.coin_valid   = 1'($urandom % 2);
            bus.coin_code    = 2'($urandom % 4);
`ifdef VEND_STOCK_EN
            bus.restock_valid = ($urandom % 24) == 0;
            bus.restock_item  = 2'($urandom % 4);
`endif
            #1;
            e_rej = 0; e_ins = 0; e_sold = 0; n_st = m_st;
            total++; if (bus.state !== 3'(m_st) || bus.credit !== 8'(m_cr) || bus.price !== 8'(m_pr)) begin
                bad++; $display("FAIL rnd_regs cyc=%0d st=%0d cr=%0d pr=%0d exp %0d/%0d/%0d", cyc, bus.state, bus.credit, bus.price, m_st, m_cr, m_pr); end
            total++; if (bus.vend_valid !== (m_st == 4) || bus.change_valid !== (m_st == 5) || bus.end_trans !== (m_st == 5)) begin
                bad++; $display("FAIL rnd_strobes cyc=%0d vend=%0d chg=%0d end=%0d st=%0d", cyc, bus.vend_valid, bus.change_valid, bus.end_trans, m_st); end
            if (m_st == 4) begin
                total++; if (bus.vend_item !== 2'(m_vitem)) begin bad++; $display("FAIL rnd_item cyc=%0d got=%0d exp=%0d", cyc, bus.vend_item, m_vitem); end
            end
            if (m_st == 5) begin
                total++; if (bus.change_amt !== 8'(m_chg)) begin bad++; $display("FAIL rnd_change cyc=%0d got=%0d exp=%0d", cyc, bus.change_amt, m_chg); end
            end
            case (m_st)
                0: if (bus.start) n_st = 1;
                1: begin
                    if (bus.cancel) n_st = 0;
                    else if (bus.item_valid) begin
                        if (m_stock[bus.item_in] > 0) begin
                            m_item = int'(bus.item_in); m_pr = prices[m_item]; n_st = 2;
                        end else e_sold = 1;
                    end
                end
                2: begin
                    add = coin_vals[bus.coin_code];
                    if (bus.coin_valid) begin
                        if (m_cr + add > 200) e_rej = 1;
                        else m_cr = m_cr + add;
                    end
                    if (bus.cancel) begin m_chg = m_cr; n_st = 5; end
                    else if (bus.done_money) n_st = 3;
                end
                3: begin
                    if (bus.cancel) begin m_chg = m_cr; n_st = 5; end
                    else if (m_cr >= m_pr) begin m_vitem = m_item; n_st = 4; end
                    else begin e_ins = 1; n_st = 2; end
                end
                4: begin
                    m_chg = m_cr - m_pr; n_st = 5;
`ifdef VEND_STOCK_EN
                    if (m_stock[m_item] > 0) m_stock[m_item]--;
`endif
                end
                default: begin m_cr = 0; n_st = bus.continue_buy ? 1 : 0; end
            endcase
`ifdef VEND_STOCK_EN
            if (bus.restock_valid) m_stock[bus.restock_item] = 15;
`endif
            total++; if (bus.coin_reject !== 1'(e_rej) || bus.insufficient !== 1'(e_ins) || bus.sold_out !== 1'(e_sold)) begin
                bad++; $display("FAIL rnd_events cyc=%0d rej=%0d ins=%0d sold=%0d exp %0d/%0d/%0d", cyc, bus.coin_reject, bus.insufficient, bus.sold_out, e_rej, e_ins, e_sold); end
            m_st = n_st;
            tick();
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_purchase();
        test_insufficient();
        test_coin_reject();
        test_cancel();
        test_reset_mid();
`ifdef VEND_STOCK_EN
        test_stock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
